// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt arbiter.
package irq_pkg;

    localparam int NUM_SRC = 4;
    localparam int CODE_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; bit 0 is the highest priority.
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic         any,
    output logic [W-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-detected pending, mask, nesting in-service
// tracking and a two-state request handshake towards the CPU.
module irq_arbiter #(
    parameter int NUM_SRC = irq_pkg::NUM_SRC,
    parameter int CODE_W  = irq_pkg::CODE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_din,
    input  logic               sti,
    input  logic               cli,
    input  logic               int_ack,
    input  logic               eret,
    output logic               int_req,
    output logic [CODE_W-1:0]  int_code,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] mask_o,
    output logic [NUM_SRC-1:0] insvc_o,
    output logic               ie_o
);

    import irq_pkg::*;

    state_t             state;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] insvc;
    logic               ie;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] prio_ok;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] pending_n;
    logic [NUM_SRC-1:0] mask_n;
    logic [NUM_SRC-1:0] insvc_n;
    logic               ie_n;
    logic               take;
    logic               code_ok;
    logic               elig_any;
    logic               svc_any;
    logic [CODE_W-1:0]  elig_idx;
    logic [CODE_W-1:0]  svc_idx;

    assign rise = irq_src & ~src_q;
    assign take = (state == REQ) && int_ack;

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (CODE_W)
    ) u_svc_enc (
        .vec (insvc),
        .any (svc_any),
        .idx (svc_idx)
    );

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (CODE_W)
    ) u_sel_enc (
        .vec (elig),
        .any (elig_any),
        .idx (elig_idx)
    );

    // Only sources strictly above the current service level may preempt.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_ok[i] = !svc_any || (CODE_W'(i) < svc_idx);
        end
        elig = pending & mask & {NUM_SRC{ie}} & prio_ok;
    end

    always_comb begin
        pending_n = pending;
        if (take) pending_n[int_code] = 1'b0;
        pending_n = pending_n | rise;

        mask_n = mask_we ? mask_din : mask;

        insvc_n = insvc;
        if (eret && svc_any) insvc_n[svc_idx] = 1'b0;
        if (take) insvc_n[int_code] = 1'b1;

        ie_n = ie;
        if (sti || eret) ie_n = 1'b1;
        if (cli || take) ie_n = 1'b0;

        // Withdraw the request on the same edge that removes eligibility.
        code_ok = pending_n[int_code] && mask_n[int_code] && ie_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            int_req  <= 1'b0;
            int_code <= '0;
            src_q    <= '0;
            pending  <= '0;
            mask     <= '0;
            insvc    <= '0;
            ie       <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= pending_n;
            mask    <= mask_n;
            insvc   <= insvc_n;
            ie      <= ie_n;
            unique case (state)
                IDLE: begin
                    if (elig_any) begin
                        state    <= REQ;
                        int_req  <= 1'b1;
                        int_code <= elig_idx;
                    end
                end
                REQ: begin
                    if (take || !code_ok) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pending_o = pending;
    assign mask_o    = mask;
    assign insvc_o   = insvc;
    assign ie_o      = ie;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_src;
    logic       mask_we;
    logic [3:0] mask_din;
    logic       sti;
    logic       cli;
    logic       int_ack;
    logic       eret;
    logic       int_req;
    logic [1:0] int_code;
    logic [3:0] pending_o;
    logic [3:0] mask_o;
    logic [3:0] insvc_o;
    logic       ie_o;

    int checks = 0;
    int errors = 0;

    bit [3:0] m_pend, m_mask, m_insvc, m_src;
    bit       m_ie, m_req;
    int       m_code;

    always #5 clk = ~clk;

    irq_arbiter #(
        .NUM_SRC (4),
        .CODE_W  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_src   (irq_src),
        .mask_we   (mask_we),
        .mask_din  (mask_din),
        .sti       (sti),
        .cli       (cli),
        .int_ack   (int_ack),
        .eret      (eret),
        .int_req   (int_req),
        .int_code  (int_code),
        .pending_o (pending_o),
        .mask_o    (mask_o),
        .insvc_o   (insvc_o),
        .ie_o      (ie_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 4;
    endfunction

    function automatic bit elig(input int i, input bit [3:0] p,
                                input bit [3:0] mk, input bit [3:0] sv,
                                input bit e);
        return p[i] && mk[i] && e && (i < lowest(sv));
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_insvc = 0; m_src = 0;
        m_ie = 0; m_req = 0; m_code = 0;
    endtask

    task automatic model_step();
        bit [3:0] p, mk, sv;
        bit       e, take;
        int       lo;
        take = m_req && int_ack;
        p = m_pend;
        if (take) p[m_code] = 0;
        for (int i = 0; i < 4; i++) if (irq_src[i] && !m_src[i]) p[i] = 1;
        mk = mask_we ? mask_din : m_mask;
        sv = m_insvc;
        lo = lowest(sv);
        if (eret && lo < 4) sv[lo] = 0;
        if (take) sv[m_code] = 1;
        e = m_ie;
        if (sti || eret) e = 1;
        if (cli || take) e = 0;
        if (!m_req) begin
            for (int i = 0; i < 4; i++) begin
                if (!m_req && elig(i, m_pend, m_mask, m_insvc, m_ie)) begin
                    m_req = 1;
                    m_code = i;
                end
            end
        end else if (take || !elig(m_code, p, mk, sv, e)) begin
            m_req = 0;
        end
        m_pend = p; m_mask = mk; m_insvc = sv; m_ie = e; m_src = irq_src;
    endtask

    task automatic compare_all();
        chk("int_req", int_req, m_req);
        chk("int_code", int_code, m_code);
        chk("pending", pending_o, m_pend);
        chk("mask", mask_o, m_mask);
        chk("insvc", insvc_o, m_insvc);
        chk("ie", ie_o, m_ie);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        mask_we = 0; sti = 0; cli = 0; int_ack = 0; eret = 0;
    endtask

    initial begin
        rst_n = 0; irq_src = 0; mask_we = 0; mask_din = 0;
        sti = 0; cli = 0; int_ack = 0; eret = 0;
        model_reset();
        #12;
        compare_all();
        rst_n = 1;

        // Single source: pending then request two edges later.
        mask_we = 1; mask_din = 4'hF; sti = 1; tick();
        irq_src = 4'b0100; tick();
        chk("r21_pend", pending_o, 4'b0100);
        chk("r21_noreq", int_req, 0);
        irq_src = 0; tick();
        chk("r21_req", int_req, 1);
        chk("r21_code", int_code, 2);
        int_ack = 1; tick();
        chk("r21_insvc", insvc_o, 4'b0100);
        chk("r21_ie", ie_o, 0);
        chk("r21_drop", int_req, 0);

        // Nesting: lower priority blocked, higher priority preempts.
        sti = 1; tick();
        irq_src = 4'b1000; tick();
        irq_src = 0; tick(); tick();
        chk("r23_block", int_req, 0);
        irq_src = 4'b0001; tick();
        irq_src = 0; tick();
        chk("r23_req", int_req, 1);
        chk("r23_code", int_code, 0);
        int_ack = 1; tick();
        chk("r23_insvc", insvc_o, 4'b0101);
        eret = 1; tick();
        eret = 1; tick();
        tick();
        chk("r23_src3", int_code, 3);
        int_ack = 1; tick();
        eret = 1; tick();

        // Simultaneous arrivals: lower index first, other after eret.
        irq_src = 4'b1010; tick();
        irq_src = 0; tick();
        chk("r22_code1", int_code, 1);
        int_ack = 1; tick();
        eret = 1; tick();
        tick();
        chk("r22_req3", int_req, 1);
        chk("r22_code3", int_code, 3);
        int_ack = 1; tick();
        eret = 1; tick();

        // cli withdraws the request, sti brings it back.
        irq_src = 4'b0010; tick();
        irq_src = 0; tick();
        chk("r24_req", int_req, 1);
        cli = 1; tick();
        chk("r24_drop", int_req, 0);
        chk("r24_pend1", pending_o[1], 1);
        sti = 1; tick();
        tick();
        chk("r24_again", int_req, 1);
        chk("r24_code", int_code, 1);

        // New edge wins over ack clear; async reset drops request.
        irq_src = 4'b0010; int_ack = 1; tick();
        chk("r25_pend", pending_o[1], 1);
        chk("r25_insvc", insvc_o, 4'b0010);
        irq_src = 0; eret = 1; tick();
        tick();
        chk("r25_req", int_req, 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("r25_rst_req", int_req, 0);
        chk("r25_rst_code", int_code, 0);
        chk("r25_rst_pend", pending_o, 0);
        chk("r25_rst_mask", mask_o, 0);
        chk("r25_rst_insvc", insvc_o, 0);
        chk("r25_rst_ie", ie_o, 0);
        #2 rst_n = 1;
        tick(); tick();
        chk("r25_no_replay", int_req, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            irq_src  = irq_src ^ (4'($urandom) & 4'($urandom));
            mask_we  = ($urandom % 16) == 0;
            mask_din = 4'($urandom);
            sti      = ($urandom % 4) == 0;
            cli      = ($urandom % 12) == 0;
            int_ack  = m_req ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            eret     = ($urandom % 6) == 0;
            tick();
            if (($urandom % 500) == 0) begin
                rst_n = 0;
                #1;
                model_reset();
                compare_all();
                #2 rst_n = 1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
